// File: rtl/abm_pkg.sv
// Shared definitions for the burst splitter: FSM states, AXI-style response
// codes and the maximum beats a single downstream burst may carry.
package abm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } abm_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_BURST_BEATS = 256;

endpackage

// File: rtl/abm_burst_splitter.sv
// Splits one large transfer request into downstream bursts that never exceed
// 256 beats and never cross a BOUNDARY-byte address boundary.
module abm_burst_splitter
    import abm_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int XFER_BEATS_W = 16,
    parameter int BOUNDARY     = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xfer_req,
    input  logic                    xfer_op,
    input  logic [ADDR_W-1:0]       xfer_addr,
    input  logic [XFER_BEATS_W-1:0] xfer_beats,
    output logic                    xfer_ack,
    output logic                    xfer_busy,
    output logic                    xfer_done,
    output logic [1:0]              xfer_status,
    output logic                    cmd_start_req,
    input  logic                    cmd_start_ack,
    output logic                    axi_cmd_op,
    output logic [ADDR_W-1:0]       axi_cmd_address,
    output logic [7:0]              axi_cmd_burst_len,
    input  logic                    burst_done,
    input  logic [1:0]              burst_resp
);

    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int OFF_W   = $clog2(BOUNDARY);
    // Wide enough for the remaining count, BOUNDARY/BYTES and 256 side by side.
    localparam int CALC_W0 = ((XFER_BEATS_W > OFF_W) ? XFER_BEATS_W : OFF_W) + 2;
    localparam int CALC_W  = (CALC_W0 > 10) ? CALC_W0 : 10;

    abm_state_t              state_reg, state_next;
    logic                    op_reg, op_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [XFER_BEATS_W-1:0] remaining_reg, remaining_next;
    logic [8:0]              beats_reg, beats_next;
    logic [7:0]              len_reg, len_next;
    logic [1:0]              status_reg, status_next;
    logic                    err_reg, err_next;
    logic                    ack_reg, ack_next;

    logic [CALC_W-1:0]       to_boundary;
    logic [CALC_W-1:0]       calc_beats;
    logic                    misaligned;

    assign misaligned = (xfer_addr & ADDR_W'(BYTES - 1)) != '0;

    always_comb begin
        to_boundary = (CALC_W'(BOUNDARY) - CALC_W'(addr_reg[OFF_W-1:0])) >> BYTE_SH;
        calc_beats  = CALC_W'(remaining_reg);
        if (CALC_W'(MAX_BURST_BEATS) < calc_beats) begin
            calc_beats = CALC_W'(MAX_BURST_BEATS);
        end
        if (to_boundary < calc_beats) begin
            calc_beats = to_boundary;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        beats_next     = beats_reg;
        len_next       = len_reg;
        status_next    = status_reg;
        err_next       = err_reg;
        ack_next       = 1'b0;

        // Burst completion is shared by WAIT and the ack+done shortcut in ISSUE.
        if ((state_reg == S_WAIT && burst_done) ||
            (state_reg == S_ISSUE && cmd_start_ack && burst_done)) begin
            status_next    = status_reg | burst_resp;
            addr_next      = addr_reg + (ADDR_W'(beats_reg) << BYTE_SH);
            remaining_next = remaining_reg - XFER_BEATS_W'(beats_reg);
            state_next     = (remaining_reg == XFER_BEATS_W'(beats_reg)) ? S_DONE : S_CALC;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (xfer_req) begin
                        op_next        = xfer_op;
                        addr_next      = xfer_addr;
                        remaining_next = xfer_beats;
                        err_next       = misaligned;
                        status_next    = misaligned ? RESP_SLVERR : RESP_OKAY;
                        ack_next       = 1'b1;
                        state_next     = S_CALC;
                    end
                end
                S_CALC: begin
                    if (err_reg || remaining_reg == '0) begin
                        state_next = S_DONE;
                    end else begin
                        beats_next = calc_beats[8:0];
                        len_next   = 8'(calc_beats - CALC_W'(1));
                        state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_start_ack) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                end
                S_DONE: begin
                    err_next   = 1'b0;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            op_reg        <= 1'b0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            beats_reg     <= '0;
            len_reg       <= '0;
            status_reg    <= '0;
            err_reg       <= 1'b0;
            ack_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            beats_reg     <= beats_next;
            len_reg       <= len_next;
            status_reg    <= status_next;
            err_reg       <= err_next;
            ack_reg       <= ack_next;
        end
    end

    assign xfer_ack          = ack_reg;
    assign xfer_busy         = (state_reg != S_IDLE);
    assign xfer_done         = (state_reg == S_DONE);
    assign xfer_status       = status_reg;
    assign cmd_start_req     = (state_reg == S_ISSUE);
    assign axi_cmd_op        = op_reg;
    assign axi_cmd_address   = addr_reg;
    assign axi_cmd_burst_len = len_reg;

endmodule

// File: tb/tb_abm_burst_splitter.sv
// Directed bench for abm_burst_splitter: a table of whole transfers with their
// expected burst sequence, plus a hand-written mid-transfer reset sequence.
module tb_abm_burst_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        xfer_req;
    logic        xfer_op;
    logic [31:0] xfer_addr;
    logic [15:0] xfer_beats;
    logic        xfer_ack;
    logic        xfer_busy;
    logic        xfer_done;
    logic [1:0]  xfer_status;
    logic        cmd_start_req;
    logic        cmd_start_ack;
    logic        axi_cmd_op;
    logic [31:0] axi_cmd_address;
    logic [7:0]  axi_cmd_burst_len;
    logic        burst_done;
    logic [1:0]  burst_resp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    abm_burst_splitter dut (
        .clk               (clk),
        .reset             (reset),
        .xfer_req          (xfer_req),
        .xfer_op           (xfer_op),
        .xfer_addr         (xfer_addr),
        .xfer_beats        (xfer_beats),
        .xfer_ack          (xfer_ack),
        .xfer_busy         (xfer_busy),
        .xfer_done         (xfer_done),
        .xfer_status       (xfer_status),
        .cmd_start_req     (cmd_start_req),
        .cmd_start_ack     (cmd_start_ack),
        .axi_cmd_op        (axi_cmd_op),
        .axi_cmd_address   (axi_cmd_address),
        .axi_cmd_burst_len (axi_cmd_burst_len),
        .burst_done        (burst_done),
        .burst_resp        (burst_resp)
    );

    typedef struct packed {
        logic              op;
        logic [31:0]       addr;
        logic [15:0]       beats;
        logic [2:0]        n;
        logic              coinc;
        logic [3:0][31:0]  addrs;
        logic [3:0][7:0]   lens;
        logic [3:0][1:0]   resps;
        logic [1:0]        status;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input int id, input vec_t v);
        int  cyc;
        logic got;
        xfer_req   = 1'b1;
        xfer_op    = v.op;
        xfer_addr  = v.addr;
        xfer_beats = v.beats;
        cyc = 0; got = 1'b0;
        while (cyc < 10 && !got) begin
            tick(); cyc++; got = xfer_ack;
        end
        check("ack_seen", 64'(got), 64'd1);
        check("ack_latency", 64'(cyc), 64'd1);
        xfer_req = 1'b0;
        check("busy_after_ack", 64'(xfer_busy), 64'd1);
        for (int b = 0; b < int'(v.n); b++) begin
            cyc = 0; got = 1'b0;
            while (cyc < 20 && !got) begin
                tick(); cyc++; got = cmd_start_req;
            end
            check("start_seen", 64'(got), 64'd1);
            check("start_latency", 64'(cyc), 64'd1);
            check("burst_addr", 64'(axi_cmd_address), 64'(v.addrs[b]));
            check("burst_len", 64'(axi_cmd_burst_len), 64'(v.lens[b]));
            check("burst_op", 64'(axi_cmd_op), 64'(v.op));
            tick();
            check("start_held", 64'(cmd_start_req), 64'd1);
            check("addr_held", 64'(axi_cmd_address), 64'(v.addrs[b]));
            cmd_start_ack = 1'b1;
            if (v.coinc) begin
                burst_done = 1'b1;
                burst_resp = v.resps[b];
            end
            tick();
            cmd_start_ack = 1'b0;
            burst_done    = 1'b0;
            burst_resp    = 2'b00;
            check("start_dropped", 64'(cmd_start_req), 64'd0);
            if (!v.coinc) begin
                tick();
                check("wait_no_start", 64'(cmd_start_req), 64'd0);
                burst_done = 1'b1;
                burst_resp = v.resps[b];
                tick();
                burst_done = 1'b0;
                burst_resp = 2'b00;
            end
            $display("xfer %0d burst %0d addr=%08h len=%0d", id, b, v.addrs[b], v.lens[b]);
        end
        cyc = 0; got = xfer_done;
        while (cyc < 20 && !got) begin
            tick(); cyc++; got = xfer_done;
            if (cmd_start_req) check("extra_burst", 64'd1, 64'd0);
        end
        check("done_seen", 64'(got), 64'd1);
        check("status", 64'(xfer_status), 64'(v.status));
        check("busy_in_done", 64'(xfer_busy), 64'd1);
        tick();
        check("done_pulse", 64'(xfer_done), 64'd0);
        check("busy_clear", 64'(xfer_busy), 64'd0);
        check("status_held", 64'(xfer_status), 64'(v.status));
        $display("xfer %0d addr=%08h beats=%0d status=%0b", id, v.addr, v.beats, xfer_status);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"},
              64'({xfer_ack, xfer_busy, xfer_done, xfer_status, cmd_start_req,
                   axi_cmd_op, axi_cmd_address, axi_cmd_burst_len}), 64'd0);
    endtask

    initial begin
        int   cyc;
        logic got;
        vec_t v;

        // Index 0 of each packed array is the rightmost element of the concatenation.
        vecs[0] = '{op: 1'b0, addr: 32'h0000_0FF0, beats: 16'd8, n: 3'd2, coinc: 1'b0,
                    addrs: {32'h0, 32'h0, 32'h0000_1000, 32'h0000_0FF0},
                    lens: {8'd0, 8'd0, 8'd3, 8'd3}, resps: {2'b00, 2'b00, 2'b00, 2'b00},
                    status: 2'b00};
        vecs[1] = '{op: 1'b1, addr: 32'h0, beats: 16'd300, n: 3'd2, coinc: 1'b0,
                    addrs: {32'h0, 32'h0, 32'h0000_0400, 32'h0},
                    lens: {8'd0, 8'd0, 8'd43, 8'd255}, resps: {2'b00, 2'b00, 2'b01, 2'b00},
                    status: 2'b01};
        vecs[2] = '{op: 1'b0, addr: 32'h0, beats: 16'd1024, n: 3'd4, coinc: 1'b1,
                    addrs: {32'h0000_0C00, 32'h0000_0800, 32'h0000_0400, 32'h0},
                    lens: {8'd255, 8'd255, 8'd255, 8'd255}, resps: {2'b00, 2'b00, 2'b00, 2'b00},
                    status: 2'b00};
        vecs[3] = '{op: 1'b1, addr: 32'h0000_0FFC, beats: 16'd3, n: 3'd2, coinc: 1'b0,
                    addrs: {32'h0, 32'h0, 32'h0000_1000, 32'h0000_0FFC},
                    lens: {8'd0, 8'd0, 8'd1, 8'd0}, resps: {2'b00, 2'b00, 2'b10, 2'b00},
                    status: 2'b10};
        vecs[4] = '{op: 1'b0, addr: 32'h0000_0002, beats: 16'd4, n: 3'd0, coinc: 1'b0,
                    addrs: '0, lens: '0, resps: '0, status: 2'b10};
        vecs[5] = '{op: 1'b1, addr: 32'h0000_0100, beats: 16'd0, n: 3'd0, coinc: 1'b0,
                    addrs: '0, lens: '0, resps: '0, status: 2'b00};
        vecs[6] = '{op: 1'b0, addr: 32'hFFFF_FFF8, beats: 16'd4, n: 3'd2, coinc: 1'b1,
                    addrs: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8},
                    lens: {8'd0, 8'd0, 8'd1, 8'd1}, resps: {2'b00, 2'b00, 2'b10, 2'b01},
                    status: 2'b11};

        reset = 1'b1; xfer_req = 1'b0; xfer_op = 1'b0; xfer_addr = '0; xfer_beats = '0;
        cmd_start_ack = 1'b0; burst_done = 1'b0; burst_resp = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset_state");

        // Stray burst_done while idle must not start anything.
        burst_done = 1'b1; burst_resp = 2'b11;
        tick();
        burst_done = 1'b0; burst_resp = 2'b00;
        tick();
        check_all_zero("idle_ignore_done");

        for (int i = 0; i < 7; i++) begin
            run_xfer(i, vecs[i]);
            repeat (2) tick();
        end

        // Reset while waiting on the second burst of a 1024-beat transfer.
        xfer_req = 1'b1; xfer_op = 1'b1; xfer_addr = 32'h0; xfer_beats = 16'd1024;
        cyc = 0; got = 1'b0;
        while (cyc < 10 && !got) begin tick(); cyc++; got = xfer_ack; end
        xfer_req = 1'b0;
        for (int b = 0; b < 2; b++) begin
            cyc = 0; got = 1'b0;
            while (cyc < 20 && !got) begin tick(); cyc++; got = cmd_start_req; end
            check("rst_seq_start", 64'(got), 64'd1);
            cmd_start_ack = 1'b1;
            tick();
            cmd_start_ack = 1'b0;
            if (b == 0) begin
                burst_done = 1'b1;
                tick();
                burst_done = 1'b0;
            end
        end
        tick();
        check("rst_seq_busy", 64'(xfer_busy), 64'd1);
        check("rst_seq_addr", 64'(axi_cmd_address), 64'h400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        got = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (xfer_done || xfer_busy || cmd_start_req) got = 1'b1;
        end
        check("no_done_after_reset", 64'(got), 64'd0);
        $display("reset mid-transfer: outputs cleared, no completion");

        v = vecs[0];
        run_xfer(7, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
